// File: rtl/tiny_dnn_out_pkg.sv
// Shared types and defaults for the accelerator output framer.
// Holds the FSM state encoding, default widths and the skid entry layout.
package tiny_dnn_out_pkg;

    localparam int DW_DEF = 64;
    localparam int LW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW_DEF-1:0]   data;
        logic [DW_DEF/8-1:0] strb;
        logic                last;
    } skid_entry_t;

endpackage

// File: rtl/tiny_dnn_axis_skid.sv
// Two-entry skid buffer with registered outputs.
// Exposes a registered full flag so upstream ready never depends on downstream ready.
module tiny_dnn_axis_skid #(
    parameter int DW = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [DW-1:0]   in_data,
    input  logic [DW/8-1:0] in_strb,
    input  logic            in_last,
    output logic            full,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [DW/8-1:0] out_strb,
    output logic            out_last,
    input  logic            out_ready
);

    logic            skid_valid;
    logic [DW-1:0]   skid_data;
    logic [DW/8-1:0] skid_strb;
    logic            skid_last;

    assign full = skid_valid;

    // The output register refills from the spare entry first so beat order is preserved;
    // when it is stalled, a new beat parks in the spare entry instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_strb   <= '0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_strb  <= '0;
            skid_last  <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid <= 1'b1;
                out_data  <= skid_data;
                out_strb  <= skid_strb;
                out_last  <= skid_last;
                if (push) begin
                    skid_data <= in_data;
                    skid_strb <= in_strb;
                    skid_last <= in_last;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else begin
                out_valid <= push;
                if (push) begin
                    out_data <= in_data;
                    out_strb <= in_strb;
                    out_last <= in_last;
                end
            end
        end else if (push) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_strb  <= in_strb;
            skid_last  <= in_last;
        end
    end

endmodule

// File: rtl/tiny_dnn_out_framer.sv
// Counts accelerator result beats against a programmed length and tags the final one with TLAST.
// Reports busy/done/err_len status for the register block.
module tiny_dnn_out_framer
    import tiny_dnn_out_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic            AXIS_ACLK,
    input  logic            AXIS_ARESETN,
    input  logic [LW-1:0]   cfg_len,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err_len,
    input  logic            S_AXIS_TVALID,
    input  logic [DW-1:0]   S_AXIS_TDATA,
    input  logic [DW/8-1:0] S_AXIS_TSTRB,
    output logic            S_AXIS_TREADY,
    output logic            M_AXIS_TVALID,
    output logic [DW-1:0]   M_AXIS_TDATA,
    output logic [DW/8-1:0] M_AXIS_TSTRB,
    output logic            M_AXIS_TLAST,
    input  logic            M_AXIS_TREADY
);

    state_t        state;
    logic [LW-1:0] len;
    logic [LW-1:0] cnt;
    logic          skid_full;
    logic          push;
    logic          is_last;

    assign S_AXIS_TREADY = (state == RUN) && !skid_full;
    assign push          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign is_last       = (cnt == len - LW'(1));

    tiny_dnn_axis_skid #(.DW(DW)) u_skid (
        .clk       (AXIS_ACLK),
        .rst_n     (AXIS_ARESETN),
        .push      (push),
        .in_data   (S_AXIS_TDATA),
        .in_strb   (S_AXIS_TSTRB),
        .in_last   (is_last),
        .full      (skid_full),
        .out_valid (M_AXIS_TVALID),
        .out_data  (M_AXIS_TDATA),
        .out_strb  (M_AXIS_TSTRB),
        .out_last  (M_AXIS_TLAST),
        .out_ready (M_AXIS_TREADY)
    );

    // Input closes as soon as the last beat is pushed, so cnt cannot wrap within a packet.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state   <= IDLE;
            len     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err_len <= 1'b0;
        end else begin
            done    <= 1'b0;
            err_len <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_len != '0) begin
                            len   <= cfg_len;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else begin
                            err_len <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (push) begin
                        cnt <= cnt + LW'(1);
                        if (is_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tiny_dnn_out_framer.sv
// Scoreboard bench for the output framer: expected beats are queued on input handshakes
// and checked against every master-side beat, along with status pulses.
module tb_tiny_dnn_out_framer;
    import tiny_dnn_out_pkg::*;

    localparam int DW = 64;
    localparam int LW = 16;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic          start = 1'b0;
    logic          busy, done, err_len;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic [SW-1:0] s_strb = '0;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_strb;
    logic          m_last;
    logic          m_ready = 1'b1;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          stalls = 0;
    int          pkt_len = 0;
    int          pkt_idx = 0;
    bit          toggle_mode = 1'b0;
    bit          done_due = 1'b0;
    skid_entry_t exp_q[$];

    tiny_dnn_out_framer #(.DW(DW), .LW(LW)) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESETN  (rst_n),
        .cfg_len       (cfg_len),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err_len       (err_len),
        .S_AXIS_TVALID (s_valid),
        .S_AXIS_TDATA  (s_data),
        .S_AXIS_TSTRB  (s_strb),
        .S_AXIS_TREADY (s_ready),
        .M_AXIS_TVALID (m_valid),
        .M_AXIS_TDATA  (m_data),
        .M_AXIS_TSTRB  (m_strb),
        .M_AXIS_TLAST  (m_last),
        .M_AXIS_TREADY (m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Downstream ready: held high, or toggling every cycle in stall mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = toggle_mode ? ~m_ready : 1'b1;
        end
    end

    // Master-side monitor: every visible beat must match the queue head, held while stalled.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("done", done, done_due);
            if (done_due) checkOutput("busy_after_done", busy, 1'b0);
            done_due = 1'b0;
            if (exp_q.size() > 0) checkOutput("m_valid_pending", m_valid, 1'b1);
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_beat", m_valid, 1'b0);
                end else begin
                    checkOutput("tdata", m_data, exp_q[0].data);
                    checkOutput("tstrb", m_strb, exp_q[0].strb);
                    checkOutput("tlast", m_last, exp_q[0].last);
                    if (m_ready) begin
                        if (exp_q[0].last) done_due = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic applyStart(input int len);
        @(posedge clk);
        #1;
        start   = 1'b1;
        cfg_len = LW'(len);
        @(posedge clk);
        #1;
        start   = 1'b0;
        pkt_len = len;
        pkt_idx = 0;
    endtask

    task automatic applyStimulus(input int n);
        skid_entry_t e;
        int w;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = {$urandom, $urandom};
            s_strb  = SW'($urandom);
            w = 0;
            @(negedge clk);
            while (!s_ready && w < 100) begin
                stalls++;
                w++;
                @(negedge clk);
            end
            if (w >= 100) begin
                checkOutput("s_ready_timeout", s_ready, 1'b1);
                break;
            end
            @(posedge clk);
            e.data = s_data;
            e.strb = s_strb;
            e.last = (pkt_idx == pkt_len - 1);
            exp_q.push_back(e);
            pkt_idx++;
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int w = 0;
        while ((exp_q.size() > 0 || busy) && w < 300) begin
            @(negedge clk);
            w++;
        end
        checkOutput("drain_timeout", (w < 300), 1'b1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic offerBlocked(input int n);
        s_valid = 1'b1;
        s_data  = 64'hDEAD_BEEF_0000_0001;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("s_ready_blocked", s_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    initial begin
        int c0;
        #1;
        checkOutput("rst_s_ready", s_ready, 1'b0);
        checkOutput("rst_m_valid", m_valid, 1'b0);
        checkOutput("rst_m_last", m_last, 1'b0);
        checkOutput("rst_m_data", m_data, '0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_err", err_len, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Four back-to-back beats at full throughput.
        applyStart(4);
        checkOutput("busy_run", busy, 1'b1);
        c0 = cyc;
        applyStimulus(4);
        checkOutput("throughput", cyc - c0, 4);
        waitIdle();
        checkOutput("busy_idle", busy, 1'b0);

        // Single-beat packet; further beats stay blocked.
        applyStart(1);
        applyStimulus(1);
        offerBlocked(6);
        waitIdle();

        // Toggling downstream ready fills the skid buffer.
        toggle_mode = 1'b1;
        stalls = 0;
        applyStart(8);
        applyStimulus(8);
        waitIdle();
        checkOutput("stall_seen", (stalls > 0), 1'b1);
        toggle_mode = 1'b0;
        @(posedge clk);
        @(posedge clk);

        // Zero length is rejected.
        applyStart(0);
        checkOutput("err_pulse", err_len, 1'b1);
        checkOutput("err_busy", busy, 1'b0);
        offerBlocked(4);
        checkOutput("err_cleared", err_len, 1'b0);
        checkOutput("err_busy_later", busy, 1'b0);

        // Reset mid-packet, then a clean 2-beat packet.
        applyStart(6);
        applyStimulus(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_m_valid", m_valid, 1'b0);
        checkOutput("mid_rst_m_last", m_last, 1'b0);
        checkOutput("mid_rst_m_data", m_data, '0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_s_ready", s_ready, 1'b0);
        exp_q.delete();
        done_due = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStart(2);
        applyStimulus(2);
        waitIdle();

        // A start pulse mid-packet is ignored.
        applyStart(5);
        applyStimulus(2);
        @(posedge clk);
        #1;
        start   = 1'b1;
        cfg_len = LW'(3);
        @(posedge clk);
        #1;
        start   = 1'b0;
        checkOutput("ign_err", err_len, 1'b0);
        checkOutput("ign_busy", busy, 1'b1);
        applyStimulus(3);
        waitIdle();
        checkOutput("ign_s_ready", s_ready, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
